// File: rtl/and_gate_mul_seq.sv
// Shift-add multiply sequencer driving an external gated-AND slice; one op in flight.
// Latency WIDTH RUN cycles after accept (data-dependent when MUL_EARLY_EXIT_EN is defined).
// Backpressure: in_ready only in IDLE; product held in DONE until out_ready.
module and_gate_mul_seq #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic [WIDTH-1:0]     and_a,
  output logic                 and_s,
  input  logic [WIDTH-1:0]     and_res,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state;
  logic [WIDTH-1:0]   aReg;
  logic [WIDTH-1:0]   bReg;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] partial;
  logic [CW-1:0]      cnt;
  logic               lastStep;

  assign partial = {{WIDTH{1'b0}}, and_res} << cnt;

`ifdef MUL_EARLY_EXIT_EN
  // Stop as soon as no multiplier bits remain above the one being added now.
  assign lastStep = (cnt == LAST) || ((bReg >> 1) == '0);
`else
  assign lastStep = (cnt == LAST);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      aReg  <= '0;
      bReg  <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            aReg  <= op_a;
            bReg  <= op_b;
            acc   <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc  <= acc + partial;
          bReg <= bReg >> 1;
          // cnt stops at its final value instead of wrapping
          if (lastStep) state <= DONE;
          else          cnt   <= cnt + CW'(1);
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);
  // Slice inputs are forced to zero outside RUN so its output is quiet.
  assign and_a     = (state == RUN) ? aReg : '0;
  assign and_s     = (state == RUN) && bReg[0];
  assign product   = out_valid ? acc : '0;

endmodule

// File: tb/tb_and_gate_mul_seq.sv
// Directed bench for and_gate_mul_seq with a behavioural gated-AND slice beside it.
// Expected latencies follow the MUL_EARLY_EXIT_EN build selection.
module tb_and_gate_mul_seq;

`ifdef MUL_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic [3:0] and_a;
  logic       and_s;
  logic [3:0] and_res;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] product;
  logic       busy;

  int nErr = 0;
  int nChk = 0;

  always #5 clk = ~clk;

  assign and_res = and_a & {4{and_s}};

  and_gate_mul_seq #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b),
    .and_a(and_a), .and_s(and_s), .and_res(and_res),
    .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChk++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one step after the accept edge; counts RUN edges until out_valid.
  task automatic waitDone(output int n, output logic [3:0] sb, output logic [3:0] aSeen);
    n = 0;
    sb = '0;
    aSeen = '0;
    while (!out_valid && n < 20) begin
      if (n < 4) sb[n] = and_s;
      if (n == 0) aSeen = and_a;
      tick();
      n++;
    end
    if (!out_valid) chk("timeout", {31'b0, out_valid}, 32'd1);
  endtask

  task automatic doOp(input string tag, input logic [3:0] a, input logic [3:0] b,
                      input logic [7:0] expP, input int expLat,
                      output logic [3:0] sb, output logic [3:0] aSeen);
    int n;
    chk({tag, ".inReady"}, {31'b0, in_ready}, 32'd1);
    op_a = a;
    op_b = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, ".busy"}, {31'b0, busy}, 32'd1);
    waitDone(n, sb, aSeen);
    chk({tag, ".latency"}, n, expLat);
    chk({tag, ".product"}, {24'b0, product}, {24'b0, expP});
  endtask

  initial begin
    logic [3:0] sb;
    logic [3:0] aSeen;
    int n;
    logic sawValid;

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op_a = '0;
    op_b = '0;
    #2;
    chk("rst.inReady", {31'b0, in_ready}, 32'd1);
    chk("rst.outValid", {31'b0, out_valid}, 32'd0);
    chk("rst.busy", {31'b0, busy}, 32'd0);
    chk("rst.product", {24'b0, product}, 32'd0);
    chk("rst.andA", {28'b0, and_a}, 32'd0);
    chk("rst.andS", {31'b0, and_s}, 32'd0);
    #10;
    rst_n = 1'b1;
    tick();

    // 13*11 with consumer always ready
    out_ready = 1'b1;
    doOp("t1", 4'd13, 4'd11, 8'h8F, 4, sb, aSeen);
    chk("t1.sBits", {28'b0, sb}, 32'hB);
    tick();
    chk("t1.dropValid", {31'b0, out_valid}, 32'd0);
    chk("t1.backIdle", {31'b0, in_ready}, 32'd1);

    // 15*15: slice sees multiplicand F and a run of ones
    doOp("t2", 4'd15, 4'd15, 8'hE1, 4, sb, aSeen);
    chk("t2.sBits", {28'b0, sb}, 32'hF);
    chk("t2.andA", {28'b0, aSeen}, 32'hF);
    tick();

    // 9*6 held in DONE while in_valid pulses with other operands
    out_ready = 1'b0;
    doOp("t3", 4'd9, 4'd6, 8'h36, EE ? 3 : 4, sb, aSeen);
    for (int i = 0; i < 5; i++) begin
      op_a = 4'd15;
      op_b = 4'd15;
      in_valid = (i % 2 == 0);
      tick();
      chk("t3.holdValid", {31'b0, out_valid}, 32'd1);
      chk("t3.holdProduct", {24'b0, product}, 32'h36);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("t3.release", {31'b0, out_valid}, 32'd0);
    tick();
    chk("t3.noQueue", {31'b0, busy}, 32'd0);

    // reset during the second RUN cycle of 7*7
    op_a = 4'd7;
    op_b = 4'd7;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("t4.running", {31'b0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4.busy", {31'b0, busy}, 32'd0);
    chk("t4.inReady", {31'b0, in_ready}, 32'd1);
    chk("t4.outValid", {31'b0, out_valid}, 32'd0);
    chk("t4.product", {24'b0, product}, 32'd0);
    chk("t4.andA", {28'b0, and_a}, 32'd0);
    chk("t4.andS", {31'b0, and_s}, 32'd0);
    #2;
    rst_n = 1'b1;
    sawValid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) sawValid = 1'b1;
    end
    chk("t4.noResult", {31'b0, sawValid}, 32'd0);
    doOp("t4b", 4'd3, 4'd5, 8'h0F, EE ? 3 : 4, sb, aSeen);
    tick();

    // in_valid held high across two back-to-back operations
    op_a = 4'd2;
    op_b = 4'd3;
    in_valid = 1'b1;
    tick();
    chk("t5.accept1", {31'b0, busy}, 32'd1);
    op_a = 4'd4;
    op_b = 4'd4;
    waitDone(n, sb, aSeen);
    chk("t5.lat1", n, EE ? 2 : 4);
    chk("t5.product1", {24'b0, product}, 32'h06);
    tick();
    chk("t5.idleReady", {31'b0, in_ready}, 32'd1);
    chk("t5.idleValid", {31'b0, out_valid}, 32'd0);
    tick();
    chk("t5.accept2", {31'b0, busy}, 32'd1);
    in_valid = 1'b0;
    waitDone(n, sb, aSeen);
    chk("t5.lat2", n, EE ? 3 : 4);
    chk("t5.product2", {24'b0, product}, 32'h10);
    tick();

    // latency dependence on the multiplier's top set bit
    doOp("t6a", 4'd7, 4'd1, 8'h07, EE ? 1 : 4, sb, aSeen);
    tick();
    doOp("t6b", 4'd5, 4'd4, 8'h14, EE ? 3 : 4, sb, aSeen);
    tick();
    doOp("t6zero", 4'd0, 4'd9, 8'h00, 4, sb, aSeen);
    tick();

    $display("Result: errors=%0d of %0d checks", nErr, nChk);
    $finish;
  end

endmodule
